// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/MEM-stage requesters, the memory port and the arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        d_read;
  logic        d_write;
  logic        d_byte;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        halt;
  logic        mem_req;
  logic        mem_we;
  logic        mem_byte;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        halted;
  logic        proto_err;

  modport slave (
    input  if_req, if_addr, d_read, d_write, d_byte, d_addr, d_wdata, halt,
           mem_rdata, mem_ack,
    output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_byte,
           mem_addr, mem_wdata, stall_if, stall_mem, halted, proto_err
  );

  modport master (
    output if_req, if_addr, d_read, d_write, d_byte, d_addr, d_wdata, halt,
           mem_rdata, mem_ack,
    input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_byte,
           mem_addr, mem_wdata, stall_if, stall_mem, halted, proto_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for instruction fetch and MEM-stage data accesses.
// States: IDLE arbitrate | DATA/FETCH access in flight | RESP done pulse | HALTED quiesced
module mem_port_arbiter (
  input  logic               clk,
  input  logic               reset_n,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_FETCH,
    ST_RESP,
    ST_HALTED
  } state_t;

  state_t      state_q;
  logic        halt_pend_q;
  logic [1:0]  cnt_q;
  logic        proto_err_q;
  logic        halted_q;
  logic        load_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic        mem_byte_q;
  logic [15:0] mem_addr_q;
  logic [15:0] mem_wdata_q;
  logic [15:0] if_rdata_q;
  logic [15:0] d_rdata_q;
  logic        if_done_q;
  logic        d_done_q;

  logic d_req;
  logic grant_fetch;

  assign d_req = bus.d_read | bus.d_write;
  // Fetch wins when alone or after two data grants taken while it was waiting.
  assign grant_fetch = bus.if_req & (~d_req | (cnt_q == 2'd2));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      halt_pend_q <= 1'b0;
      cnt_q       <= 2'd0;
      proto_err_q <= 1'b0;
      halted_q    <= 1'b0;
      load_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      if_rdata_q  <= 16'h0000;
      d_rdata_q   <= 16'h0000;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      if (bus.halt) halt_pend_q <= 1'b1;
      if (bus.d_read & bus.d_write) proto_err_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (halt_pend_q) begin
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
          end else if (grant_fetch) begin
            state_q     <= ST_FETCH;
            cnt_q       <= 2'd0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= 16'h0000;
          end else if (d_req) begin
            state_q     <= ST_DATA;
            cnt_q       <= bus.if_req ? cnt_q + 2'd1 : 2'd0;
            load_q      <= bus.d_read;
            mem_req_q   <= 1'b1;
            // A simultaneous read and write is serviced as a read.
            mem_we_q    <= ~bus.d_read;
            mem_byte_q  <= bus.d_byte;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
          end
        end
        ST_DATA: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (load_q) d_rdata_q <= bus.mem_rdata;
            d_done_q  <= 1'b1;
            state_q   <= ST_RESP;
          end
        end
        ST_FETCH: begin
          if (bus.mem_ack) begin
            mem_req_q  <= 1'b0;
            if_rdata_q <= bus.mem_rdata;
            if_done_q  <= 1'b1;
            state_q    <= ST_RESP;
          end
        end
        ST_RESP:   state_q <= ST_IDLE;
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_byte  = mem_byte_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.halted    = halted_q;
  assign bus.proto_err = proto_err_q;
  assign bus.stall_if  = bus.if_req & ~if_done_q;
  assign bus.stall_mem = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences,
// then randomized traffic checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic        rd, wr, byt;
    logic [15:0] daddr, wdata;
    logic        ifr;
    logic [15:0] iaddr, rd1, rd2;
    int          dly;
    logic        first_data, exp_we, exp_byte;
    logic [15:0] exp_d, exp_if;
    logic        exp_proto;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req = 1'b0; bus.if_addr = 16'h0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_byte = 1'b0;
    bus.d_addr = 16'h0; bus.d_wdata = 16'h0; bus.halt = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    step();
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_mem_byte", bus.mem_byte, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 16'h0);
    chk("rst_if_rdata", bus.if_rdata, 16'h0);
    chk("rst_d_rdata", bus.d_rdata, 16'h0);
    chk("rst_dones", {bus.if_done, bus.d_done}, 2'b00);
    chk("rst_halted", bus.halted, 1'b0);
    chk("rst_proto_err", bus.proto_err, 1'b0);
    reset_n = 1'b1;
  endtask

  // Entered in the first cycle mem_req should be up; leaves in the done cycle.
  task automatic serve(input int dly, input logic [15:0] rdv, input bit is_data,
                       input logic [15:0] addr, input bit we, input bit byt,
                       input logic [15:0] wd);
    chk("grant_req", bus.mem_req, 1'b1);
    chk("grant_addr", bus.mem_addr, addr);
    chk("grant_we", bus.mem_we, we);
    chk("grant_byte", bus.mem_byte, byt);
    if (we) chk("grant_wdata", bus.mem_wdata, wd);
    for (int i = 0; i < dly; i++) begin
      bus.mem_ack = 1'b0;
      step();
      chk("hold_req", bus.mem_req, 1'b1);
      chk("hold_addr", bus.mem_addr, addr);
      chk("hold_no_done", {bus.d_done, bus.if_done}, 2'b00);
      chk("hold_stall", is_data ? bus.stall_mem : bus.stall_if, 1'b1);
    end
    bus.mem_ack = 1'b1;
    bus.mem_rdata = rdv;
    step();
    bus.mem_ack = 1'b0;
    chk("d_done", bus.d_done, is_data);
    chk("if_done", bus.if_done, !is_data);
    chk("resp_req", bus.mem_req, 1'b0);
    chk("resp_stall", is_data ? bus.stall_mem : bus.stall_if, 1'b0);
    if (!is_data) chk("if_rdata", bus.if_rdata, rdv);
  endtask

  // Random-phase requester and model state
  bit          d_act, i_act, d_ret, i_ret;
  bit          r_rd, r_wr, r_byte;
  logic [15:0] r_daddr, r_wdata, r_iaddr, r_md;
  bit          ack;
  int          ph, streak, k;
  bit          e_req, e_ddone, e_idone, m_proto;
  logic [15:0] m_drd, m_ird;
  logic [15:0] c_addr, c_wd;
  bit          c_data, c_rd, c_we, c_byte;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0010, 16'h1234, 16'h0000, 0,
                1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0040, 16'hBEEF, 1'b1, 16'h0020, 16'h1111, 16'h5678, 1,
                1'b1, 1'b1, 1'b1, 16'h0000, 16'h5678, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, 16'h0000, 16'hA5A5, 16'h0000, 2,
                1'b1, 1'b0, 1'b0, 16'hA5A5, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0200, 16'h9999, 1'b0, 16'h0000, 16'h4242, 16'h0000, 0,
                1'b1, 1'b0, 1'b0, 16'h4242, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h0210, 16'h0000, 1'b1, 16'h0030, 16'h00C3, 16'h7777, 3,
                1'b1, 1'b0, 1'b1, 16'h00C3, 16'h7777, 1'b0};

    clear_inputs();

    for (int v = 0; v < 5; v++) begin
      do_reset();
      bus.d_read  = vecs[v].rd;
      bus.d_write = vecs[v].wr;
      bus.d_byte  = vecs[v].byt;
      bus.d_addr  = vecs[v].daddr;
      bus.d_wdata = vecs[v].wdata;
      bus.if_req  = vecs[v].ifr;
      bus.if_addr = vecs[v].iaddr;
      step();
      if (vecs[v].first_data)
        serve(vecs[v].dly, vecs[v].rd1, 1'b1, vecs[v].daddr, vecs[v].exp_we,
              vecs[v].exp_byte, vecs[v].wdata);
      else
        serve(vecs[v].dly, vecs[v].rd1, 1'b0, vecs[v].iaddr, 1'b0, 1'b0, 16'h0);
      step();
      if (vecs[v].first_data) begin
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
      end else begin
        bus.if_req = 1'b0;
      end
      if (vecs[v].ifr && (vecs[v].rd || vecs[v].wr)) begin
        step();
        serve(0, vecs[v].rd2, 1'b0, vecs[v].iaddr, 1'b0, 1'b0, 16'h0);
        step();
        bus.if_req = 1'b0;
      end
      step();
      chk("vec_d_rdata", bus.d_rdata, vecs[v].exp_d);
      chk("vec_if_rdata", bus.if_rdata, vecs[v].exp_if);
      chk("vec_proto_err", bus.proto_err, vecs[v].exp_proto);
      chk("vec_idle_req", bus.mem_req, 1'b0);
    end

    // Two data grants starve fetch once, then the counter restarts.
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 16'h0300;
    bus.d_read = 1'b1; bus.d_addr = 16'h0400;
    step();
    serve(0, 16'h0001, 1'b1, 16'h0400, 1'b0, 1'b0, 16'h0);
    step();
    bus.d_addr = 16'h0402;
    step();
    serve(1, 16'h0002, 1'b1, 16'h0402, 1'b0, 1'b0, 16'h0);
    step();
    bus.d_addr = 16'h0404;
    step();
    serve(0, 16'h0003, 1'b0, 16'h0300, 1'b0, 1'b0, 16'h0);
    step();
    bus.if_addr = 16'h0302;
    step();
    serve(0, 16'h0004, 1'b1, 16'h0404, 1'b0, 1'b0, 16'h0);
    step();
    bus.d_read = 1'b0;
    step();
    serve(0, 16'h0005, 1'b0, 16'h0302, 1'b0, 1'b0, 16'h0);
    step();
    bus.if_req = 1'b0;
    chk("b2b_d_rdata", bus.d_rdata, 16'h0004);
    chk("b2b_if_rdata", bus.if_rdata, 16'h0005);

    // Halt during a slow fetch: access completes, then arbiter quiesces.
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 16'h0500;
    step();
    bus.halt = 1'b1;
    serve(5, 16'hCAFE, 1'b0, 16'h0500, 1'b0, 1'b0, 16'h0);
    chk("halt_not_yet", bus.halted, 1'b0);
    step();
    bus.halt = 1'b0; bus.if_req = 1'b1; bus.if_addr = 16'h0510;
    bus.d_read = 1'b1; bus.d_addr = 16'h0700;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ack = 1'b1;
      step();
      chk("halted", bus.halted, 1'b1);
      chk("halted_req", bus.mem_req, 1'b0);
      chk("halted_dones", {bus.d_done, bus.if_done}, 2'b00);
    end
    chk("halt_if_rdata", bus.if_rdata, 16'hCAFE);

    // Reset while a load is in flight abandons it.
    do_reset();
    bus.d_read = 1'b1; bus.d_addr = 16'h0600;
    step();
    serve(0, 16'h7E7E, 1'b1, 16'h0600, 1'b0, 1'b0, 16'h0);
    chk("pre_rst_d_rdata", bus.d_rdata, 16'h7E7E);
    step();
    bus.d_addr = 16'h0602;
    step();
    chk("inflight_req", bus.mem_req, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.mem_ack = 1'b1;
      step();
      chk("abandon_d_done", bus.d_done, 1'b0);
      chk("abandon_req", bus.mem_req, 1'b0);
    end
    bus.mem_ack = 1'b0;

    // Randomized traffic against the transaction-level model.
    do_reset();
    d_act = 0; i_act = 0; d_ret = 0; i_ret = 0;
    r_rd = 0; r_wr = 0; r_byte = 0;
    r_daddr = 16'h0; r_wdata = 16'h0; r_iaddr = 16'h0;
    ph = 0; streak = 0; m_proto = 0; m_drd = 16'h0; m_ird = 16'h0;
    e_req = 0; e_ddone = 0; e_idone = 0;
    c_addr = 16'h0; c_wd = 16'h0; c_data = 0; c_rd = 0; c_we = 0; c_byte = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (d_ret) d_act = 0;
      d_ret = e_ddone;
      if (i_ret) i_act = 0;
      i_ret = e_idone;
      if (!d_act && $urandom_range(0, 2) == 0) begin
        k = int'($urandom_range(0, 15));
        d_act = 1;
        r_rd = (k < 7) || (k == 15);
        r_wr = (k >= 7);
        r_byte = 1'($urandom_range(0, 1));
        r_daddr = 16'($urandom);
        r_wdata = 16'($urandom);
      end
      if (!i_act && $urandom_range(0, 1) == 0) begin
        i_act = 1;
        r_iaddr = 16'($urandom);
      end
      bus.d_read = d_act & r_rd;
      bus.d_write = d_act & r_wr;
      bus.d_byte = r_byte;
      bus.d_addr = r_daddr;
      bus.d_wdata = r_wdata;
      bus.if_req = i_act;
      bus.if_addr = r_iaddr;
      ack = ($urandom_range(0, 2) == 0);
      r_md = 16'($urandom);
      bus.mem_ack = ack;
      bus.mem_rdata = r_md;
      #1;
      chk("rnd_stall_if", bus.stall_if, i_act & ~e_idone);
      chk("rnd_stall_mem", bus.stall_mem, d_act & ~e_ddone);

      m_proto = m_proto | (d_act & r_rd & r_wr);
      e_ddone = 0;
      e_idone = 0;
      if (ph == 0) begin
        if (d_act || i_act) begin
          if (i_act && (!d_act || streak == 2)) begin
            streak = 0;
            c_data = 0; c_rd = 0; c_we = 0; c_byte = 0;
            c_addr = r_iaddr; c_wd = 16'h0;
          end else begin
            streak = i_act ? ((streak < 2) ? streak + 1 : 2) : 0;
            c_data = 1; c_rd = r_rd; c_we = !r_rd; c_byte = r_byte;
            c_addr = r_daddr; c_wd = r_wdata;
          end
          e_req = 1;
          ph = 1;
        end else begin
          e_req = 0;
        end
      end else if (ph == 1) begin
        if (ack) begin
          if (c_data) begin
            if (c_rd) m_drd = r_md;
            e_ddone = 1;
          end else begin
            m_ird = r_md;
            e_idone = 1;
          end
          e_req = 0;
          ph = 2;
        end else begin
          e_req = 1;
        end
      end else begin
        e_req = 0;
        ph = 0;
      end

      step();
      chk("rnd_mem_req", bus.mem_req, e_req);
      if (e_req) begin
        chk("rnd_mem_addr", bus.mem_addr, c_addr);
        chk("rnd_mem_we", bus.mem_we, c_we);
        chk("rnd_mem_byte", bus.mem_byte, c_byte);
        if (c_we) chk("rnd_mem_wdata", bus.mem_wdata, c_wd);
      end
      chk("rnd_d_done", bus.d_done, e_ddone);
      chk("rnd_if_done", bus.if_done, e_idone);
      chk("rnd_d_rdata", bus.d_rdata, m_drd);
      chk("rnd_if_rdata", bus.if_rdata, m_ird);
      chk("rnd_proto_err", bus.proto_err, m_proto);
      chk("rnd_halted", bus.halted, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
